voice_allocator: RTL and testbench

Polyphonic voice scheduler sitting between the PS/2 key decoder and the waveform datapath. Accepts note-on/note-off key events over a valid/ready handshake and assigns them to one of NUM_VOICES oscillator/envelope voice slots: same-key retrigger, free slot, releasing slot, then oldest-voice steal. It drives per-voice note, octave, gate and trigger to the voice datapath, and frees slots when the envelope reports release complete.

---
 rtl/synth_pkg.sv | 19 +
 rtl/voice_slot.sv | 56 +++++
 rtl/voice_allocator.sv | 203 ++++++++++++++++++++
 tb/tb_voice_allocator.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared types and constants for the voice allocation datapath.
// Latency: n/a (types only).
// Backpressure: n/a.
package synth_pkg;

  localparam int NOTE_W   = 4;
  localparam int OCT_W    = 3;
  localparam int NOTE_MAX = 11;

  typedef logic [NOTE_W-1:0] note_t;
  typedef logic [OCT_W-1:0]  oct_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } state_t;

endpackage

// File: rtl/voice_slot.sv
// One voice slot: ownership, gate, pitch, age and envelope trigger registers.
// Latency: every update lands one clk after its control input.
// Backpressure: none; controls are single-cycle strobes from the allocator.
// Ports: load (note-on commit), gate_off (note-off commit), age_inc (another
// slot was loaded), note_in/oct_in (pitch to load), release_done (envelope
// finished); outputs active, gate, note, octave, age, trig.
module voice_slot
  import synth_pkg::*;
#(
  parameter int AGE_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             gate_off,
  input  logic             age_inc,
  input  note_t            note_in,
  input  oct_t             oct_in,
  input  logic             release_done,
  output logic             active,
  output logic             gate,
  output note_t            note,
  output oct_t             octave,
  output logic [AGE_W-1:0] age,
  output logic             trig
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      active <= 1'b0;
      gate   <= 1'b0;
      note   <= '0;
      octave <= '0;
      age    <= '0;
      trig   <= 1'b0;
    end else begin
      trig <= load;
      // A commit on this slot takes precedence over a concurrent release_done.
      if (load) begin
        active <= 1'b1;
        gate   <= 1'b1;
        note   <= note_in;
        octave <= oct_in;
        age    <= '0;
      end else if (gate_off) begin
        gate <= 1'b0;
      end else if (release_done && active && !gate) begin
        active <= 1'b0;
        age    <= '0;
      end else if (age_inc && active && (age != {AGE_W{1'b1}})) begin
        age <= age + 1'b1;
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: maps key events onto NUM_VOICES voice slots.
// Latency: handshake cycle 0, results visible cycle NUM_VOICES+2.
// Backpressure: ev_ready only in IDLE; one event per NUM_VOICES+2 cycles.
// Ports: ev_valid/ev_ready/ev_on/ev_note/ev_octave key event input;
// release_done per-voice envelope status; voice_active/gate/trig/note/octave
// per-voice outputs; ev_dropped one-cycle pulse for discarded events.
// Build option: define VOICE_STEAL_EN to let a note-on steal the oldest voice
// when every slot is gated; otherwise such an event is dropped.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ev_valid,
  output logic                      ev_ready,
  input  logic                      ev_on,
  input  logic [NOTE_W-1:0]         ev_note,
  input  logic [OCT_W-1:0]          ev_octave,
  input  logic [NUM_VOICES-1:0]     release_done,
  output logic [NUM_VOICES-1:0]     voice_active,
  output logic [NUM_VOICES-1:0]     voice_gate,
  output logic [NUM_VOICES-1:0]     voice_trig,
  output logic [4*NUM_VOICES-1:0]   voice_note,
  output logic [3*NUM_VOICES-1:0]   voice_octave,
  output logic                      ev_dropped
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             lat_on;
  note_t            lat_note;
  oct_t             lat_oct;

  // Best candidate per priority class, accumulated across the scan.
  logic             match_found, free_found, rel_found, off_found;
  logic [IDX_W-1:0] match_idx, free_idx, rel_idx, off_idx;
  logic [AGE_W-1:0] rel_age;
`ifdef VOICE_STEAL_EN
  logic             old_found;
  logic [IDX_W-1:0] old_idx;
  logic [AGE_W-1:0] old_age;
`endif

  note_t            slot_note [NUM_VOICES];
  oct_t             slot_oct  [NUM_VOICES];
  logic [AGE_W-1:0] slot_age  [NUM_VOICES];

  logic             commit_on, commit_off, drop;
  logic [IDX_W-1:0] commit_v;

  // Slot under examination this SCAN cycle.
  logic             sel_act, sel_gate, sel_key;
  logic [AGE_W-1:0] sel_age;
  assign sel_act  = voice_active[idx];
  assign sel_gate = voice_gate[idx];
  assign sel_age  = slot_age[idx];
  assign sel_key  = (slot_note[idx] == lat_note) && (slot_oct[idx] == lat_oct);

  always_comb begin
    commit_on  = 1'b0;
    commit_off = 1'b0;
    commit_v   = '0;
    drop       = 1'b0;
    if (state == COMMIT) begin
      if (lat_note > note_t'(NOTE_MAX)) begin
        drop = 1'b1;
      end else if (lat_on) begin
        commit_on = 1'b1;
        if (match_found)     commit_v = match_idx;
        else if (free_found) commit_v = free_idx;
        else if (rel_found)  commit_v = rel_idx;
        else begin
`ifdef VOICE_STEAL_EN
          commit_v = old_idx;
`else
          commit_on = 1'b0;
          drop      = 1'b1;
`endif
        end
      end else if (off_found) begin
        commit_off = 1'b1;
        commit_v   = off_idx;
      end else begin
        drop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      ev_ready    <= 1'b0;
      ev_dropped  <= 1'b0;
      idx         <= '0;
      lat_on      <= 1'b0;
      lat_note    <= '0;
      lat_oct     <= '0;
      match_found <= 1'b0;
      free_found  <= 1'b0;
      rel_found   <= 1'b0;
      off_found   <= 1'b0;
      match_idx   <= '0;
      free_idx    <= '0;
      rel_idx     <= '0;
      off_idx     <= '0;
      rel_age     <= '0;
`ifdef VOICE_STEAL_EN
      old_found   <= 1'b0;
      old_idx     <= '0;
      old_age     <= '0;
`endif
    end else begin
      ev_dropped <= 1'b0;
      case (state)
        IDLE: begin
          ev_ready <= 1'b1;
          if (ev_valid && ev_ready) begin
            lat_on      <= ev_on;
            lat_note    <= ev_note;
            lat_oct     <= ev_octave;
            idx         <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            rel_found   <= 1'b0;
            off_found   <= 1'b0;
`ifdef VOICE_STEAL_EN
            old_found   <= 1'b0;
`endif
            ev_ready    <= 1'b0;
            state       <= SCAN;
          end
        end
        SCAN: begin
          // Lowest index wins everywhere: only strictly better entries replace.
          if (sel_act && sel_key && !match_found) begin
            match_found <= 1'b1;
            match_idx   <= idx;
          end
          if (!sel_act && !free_found) begin
            free_found <= 1'b1;
            free_idx   <= idx;
          end
          if (sel_act && !sel_gate && (!rel_found || sel_age > rel_age)) begin
            rel_found <= 1'b1;
            rel_idx   <= idx;
            rel_age   <= sel_age;
          end
          if (sel_act && sel_gate && sel_key && !off_found) begin
            off_found <= 1'b1;
            off_idx   <= idx;
          end
`ifdef VOICE_STEAL_EN
          if (sel_act && (!old_found || sel_age > old_age)) begin
            old_found <= 1'b1;
            old_idx   <= idx;
            old_age   <= sel_age;
          end
`endif
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) state <= COMMIT;
        end
        COMMIT: begin
          ev_dropped <= drop;
          ev_ready   <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
    logic hit;
    assign hit = (commit_v == IDX_W'(i));

    voice_slot #(.AGE_W(AGE_W)) u_slot (
      .clk          (clk),
      .reset        (reset),
      .load         (commit_on && hit),
      .gate_off     (commit_off && hit),
      .age_inc      (commit_on && !hit),
      .note_in      (lat_note),
      .oct_in       (lat_oct),
      .release_done (release_done[i]),
      .active       (voice_active[i]),
      .gate         (voice_gate[i]),
      .note         (slot_note[i]),
      .octave       (slot_oct[i]),
      .age          (slot_age[i]),
      .trig         (voice_trig[i])
    );

    assign voice_note[4*i +: 4]   = slot_note[i];
    assign voice_octave[3*i +: 3] = slot_oct[i];
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator (NUM_VOICES=4): reset, allocation,
// retrigger, release, drop and steal/no-steal behaviour.
module tb_voice_allocator;

  localparam int NV = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ev_valid = 1'b0;
  logic          ev_ready;
  logic          ev_on = 1'b0;
  logic [3:0]    ev_note = '0;
  logic [2:0]    ev_octave = '0;
  logic [NV-1:0] release_done = '0;
  logic [NV-1:0] voice_active, voice_gate, voice_trig;
  logic [4*NV-1:0] voice_note;
  logic [3*NV-1:0] voice_octave;
  logic          ev_dropped;

  int checks = 0;
  int errors = 0;
  logic [NV-1:0] last_trig;
  logic          last_drop;

  voice_allocator #(.NUM_VOICES(NV), .AGE_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_on        (ev_on),
    .ev_note      (ev_note),
    .ev_octave    (ev_octave),
    .release_done (release_done),
    .voice_active (voice_active),
    .voice_gate   (voice_gate),
    .voice_trig   (voice_trig),
    .voice_note   (voice_note),
    .voice_octave (voice_octave),
    .ev_dropped   (ev_dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    ev_valid = 1'b0;
    release_done = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Sends one event; checks ev_ready stays low for cycles 1..5 and returns at
  // cycle 6, then captures trig/drop in that cycle.
  task automatic send(input logic on, input logic [3:0] n, input logic [2:0] o);
    int t;
    int lat;
    t = 0;
    while (!ev_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!ev_ready) check("ready_timeout", 32'(ev_ready), 32'd1);
    ev_valid = 1'b1; ev_on = on; ev_note = n; ev_octave = o;
    @(negedge clk);
    ev_valid = 1'b0;
    lat = 1;
    while (!ev_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'd6);
    last_trig = voice_trig;
    last_drop = ev_dropped;
  endtask

  initial begin
    // Reset state
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ev_ready), 32'd0);
    check("rst_active", 32'(voice_active), 32'd0);
    check("rst_trig_drop", {voice_trig, ev_dropped}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(ev_ready), 32'd1);

    // First note-on lands in slot 0
    send(1'b1, 4'd0, 3'd4);
    check("c4_trig", 32'(last_trig), 32'b0001);
    check("c4_active", 32'(voice_active), 32'b0001);
    check("c4_gate", 32'(voice_gate), 32'b0001);
    check("c4_note", 32'(voice_note[3:0]), 32'd0);
    check("c4_oct", 32'(voice_octave[2:0]), 32'd4);
    @(negedge clk);
    check("c4_trig_width", 32'(voice_trig), 32'd0);

    // Retrigger of the same key stays in slot 0
    send(1'b1, 4'd0, 3'd4);
    check("retrig_trig", 32'(last_trig), 32'b0001);
    check("retrig_active", 32'(voice_active), 32'b0001);

    // Note-off then release_done frees slot 0
    send(1'b0, 4'd0, 3'd4);
    check("off_gate", 32'(voice_gate), 32'b0000);
    check("off_active", 32'(voice_active), 32'b0001);
    check("off_nodrop", 32'(last_drop), 32'd0);
    release_done = 4'b0001;
    @(negedge clk);
    release_done = '0;
    check("rel_done_active", 32'(voice_active), 32'b0000);

    // Invalid note and unmatched note-off are dropped
    send(1'b1, 4'd13, 3'd4);
    check("bad_note_drop", 32'(last_drop), 32'd1);
    check("bad_note_trig", 32'(last_trig), 32'd0);
    check("bad_note_active", 32'(voice_active), 32'd0);
    @(negedge clk);
    check("drop_width", 32'(ev_dropped), 32'd0);
    send(1'b0, 4'd9, 3'd2);
    check("off_nomatch_drop", 32'(last_drop), 32'd1);

    // Fill all four slots, then a fifth key
    do_reset();
    send(1'b1, 4'd0, 3'd4);
    send(1'b1, 4'd2, 3'd4);
    send(1'b1, 4'd4, 3'd4);
    send(1'b1, 4'd5, 3'd4);
    check("fill_notes", 32'(voice_note), 32'h5420);
    check("fill_active", 32'(voice_active), 32'b1111);
    send(1'b1, 4'd7, 3'd4);
`ifdef VOICE_STEAL_EN
    check("steal_trig", 32'(last_trig), 32'b0001);
    check("steal_drop", 32'(last_drop), 32'd0);
    check("steal_notes", 32'(voice_note), 32'h5427);
`else
    check("nosteal_drop", 32'(last_drop), 32'd1);
    check("nosteal_trig", 32'(last_trig), 32'd0);
    check("nosteal_notes", 32'(voice_note), 32'h5420);
`endif

    // Releasing slot is reused when no slot is free
    do_reset();
    send(1'b1, 4'd0, 3'd4);
    send(1'b1, 4'd2, 3'd4);
    send(1'b1, 4'd4, 3'd4);
    send(1'b1, 4'd5, 3'd4);
    send(1'b0, 4'd2, 3'd4);
    check("rel_gate", 32'(voice_gate), 32'b1101);
    send(1'b1, 4'd9, 3'd3);
    check("reuse_trig", 32'(last_trig), 32'b0010);
    check("reuse_notes", 32'(voice_note), 32'h5490);
    check("reuse_oct", 32'(voice_octave[5:3]), 32'd3);
    release_done = 4'b0010;
    @(negedge clk);
    release_done = '0;
    check("rel_ignored_gated", 32'(voice_active), 32'b1111);

    // Reset during SCAN discards the event
    do_reset();
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 4'd3; ev_octave = 3'd2;
    @(negedge clk);
    ev_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midscan_ready", 32'(ev_ready), 32'd0);
    check("midscan_outs", {voice_active, voice_gate, voice_trig, ev_dropped}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("midscan_ready_back", 32'(ev_ready), 32'd1);
    repeat (6) begin
      @(negedge clk);
      check("midscan_quiet", {voice_active, voice_trig, ev_dropped}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
